// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS bus CPU.
// The control decoder imports the same state encoding.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        LOAD   = 3'd1,
        MEM    = 3'd2,
        EXEC   = 3'd3,
        HALTED = 3'd4
    } cpu_state_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bus/control bundle between the sequencer and the rest of the CPU.
// master is the sequencer side, slave the bus/datapath side.
interface cpu_sequencer_if;
    import cpu_pkg::*;

    logic        waitrequest;
    logic        is_mem_op;
    logic        redirect;
    logic [31:0] redirect_addr;
    cpu_state_t  state;
    logic [31:0] pc;
    logic        ir_en;
    logic        commit;
    logic        active;
    logic [31:0] instr_count;

    modport master (
        input  waitrequest, is_mem_op,
        input  redirect, redirect_addr,
        output state, pc, ir_en, commit,
        output active, instr_count
    );

    modport slave (
        output waitrequest, is_mem_op,
        output redirect, redirect_addr,
        input  state, pc, ir_en, commit,
        input  active, instr_count
    );

endinterface

// File: rtl/pc_tracker.sv
// PC and delay-slot register; the redirect lands one instruction late,
// which yields exactly one delay slot.
module pc_tracker
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        advance_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic [31:0] pc_o,
    output logic        halt_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_next_q, pc_next_d;

    always_comb begin
        pc_d      = pc_q;
        pc_next_d = pc_next_q;
        if (advance_i) begin
            pc_d      = pc_next_q;
            pc_next_d = redirect_i ? redirect_addr_i
                                   : pc_next_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q      <= RESET_VECTOR;
            pc_next_q <= RESET_VECTOR + 32'd4;
        end else begin
            pc_q      <= pc_d;
            pc_next_q <= pc_next_d;
        end
    end

    assign pc_o   = pc_q;
    // The value about to become pc is the one checked for halt.
    assign halt_o = (pc_next_q == HALT_ADDR);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle state sequencer: FETCH/LOAD/MEM/EXEC with bus stalls,
// halt detection and committed-instruction counting.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    cpu_sequencer_if.master  bus
);

    cpu_state_t  state_q, state_d;
    logic [31:0] count_q, count_d;
    logic        advance;
    logic        halt_hit;
    logic        ir_en, commit, active;

    assign advance = (state_q == EXEC);

    pc_tracker #(
        .RESET_VECTOR (RESET_VECTOR),
        .HALT_ADDR    (HALT_ADDR)
    ) u_pc (
        .clk_i           (clk),
        .reset_i         (reset),
        .advance_i       (advance),
        .redirect_i      (bus.redirect),
        .redirect_addr_i (bus.redirect_addr),
        .pc_o            (bus.pc),
        .halt_o          (halt_hit)
    );

    always_comb begin
        state_d = state_q;
        ir_en   = 1'b0;
        commit  = 1'b0;
        active  = 1'b1;
        unique case (state_q)
            FETCH: begin
                if (!bus.waitrequest) begin
                    ir_en   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = bus.is_mem_op ? MEM : EXEC;
            end
            MEM: begin
                if (!bus.waitrequest) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                commit  = 1'b1;
                state_d = halt_hit ? HALTED : FETCH;
            end
            HALTED: begin
                active = 1'b0;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign count_d = commit ? count_q + 32'd1 : count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Strobes are suppressed while reset is held so nothing is captured.
    assign bus.state       = state_q;
    assign bus.ir_en       = ir_en & ~reset;
    assign bus.commit      = commit & ~reset;
    assign bus.active      = active;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus queues expected
// commits, a negedge monitor checks them as the DUT retires.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;

    cpu_sequencer_if bus ();

    cpu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic [7:0]  nf;
        logic [7:0]  nm;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int nf = 0, nl = 0, nm = 0, nir = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: tally cycles per state, compare on each commit.
    always @(negedge clk) begin
        if (reset) begin
            nf = 0; nl = 0; nm = 0; nir = 0;
        end else begin
            if (bus.ir_en) nir++;
            case (bus.state)
                3'd0: nf++;
                3'd1: nl++;
                3'd2: nm++;
                default: ;
            endcase
            if (bus.commit) begin
                if (q.size() == 0) begin
                    chk("commit_unexpected", bus.pc, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("exec_pc", bus.pc, e.pc);
                    chk("exec_count", bus.instr_count, e.cnt);
                    chk("cycles_f_l_m_ir",
                        {nf[7:0], nl[7:0], nm[7:0], nir[7:0]},
                        {e.nf, 8'd1, e.nm, 8'd1});
                end
                nf = 0; nl = 0; nm = 0; nir = 0;
            end
        end
    end

    task automatic run_instr(input int fw, input bit mem,
                             input int mw, input bit rd,
                             input logic [31:0] ra,
                             input logic [31:0] epc,
                             input logic [31:0] ecnt);
        exp_t e;
        e.pc  = epc;
        e.cnt = ecnt;
        e.nf  = 8'(fw + 1);
        e.nm  = mem ? 8'(mw + 1) : 8'd0;
        q.push_back(e);
        bus.redirect = 1'b0;
        for (int i = 0; i < fw; i++) begin
            bus.waitrequest = 1'b1;
            step();
        end
        bus.waitrequest = 1'b0;
        step();
        // LOAD: stray waitrequest/redirect must be ignored
        bus.waitrequest   = 1'b1;
        bus.is_mem_op     = mem;
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'hDEAD_BEE0;
        step();
        bus.redirect = 1'b0;
        if (mem) begin
            for (int i = 0; i < mw; i++) begin
                bus.waitrequest = 1'b1;
                step();
            end
            bus.waitrequest = 1'b0;
            step();
        end
        bus.is_mem_op     = 1'b0;
        bus.waitrequest   = 1'b1;
        bus.redirect      = rd;
        bus.redirect_addr = ra;
        step();
        bus.redirect    = 1'b0;
        bus.waitrequest = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.waitrequest = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] s_pc, s_cnt, s_ctl;
        bus.waitrequest   = 1'b0;
        bus.is_mem_op     = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = 32'h0;
        step();
        reset = 1'b1;
        step();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_pc", bus.pc, 32'hBFC0_0000);
        chk("rst_count", bus.instr_count, 32'd0);
        chk("rst_strobes",
            {29'd0, bus.active, bus.ir_en, bus.commit}, 32'd4);
        reset = 1'b0;

        run_instr(0, 0, 0, 0, 0, 32'hBFC0_0000, 32'd0);
        run_instr(0, 0, 0, 0, 0, 32'hBFC0_0004, 32'd1);
        chk("count_after_2", bus.instr_count, 32'd2);
        chk("pc_after_2", bus.pc, 32'hBFC0_0008);
        run_instr(3, 1, 2, 0, 0, 32'hBFC0_0008, 32'd2);
        run_instr(0, 1, 0, 0, 0, 32'hBFC0_000C, 32'd3);

        // Reset while stalled in MEM abandons the transfer
        bus.waitrequest = 1'b0;
        step();
        bus.is_mem_op = 1'b1;
        step();
        bus.is_mem_op   = 1'b0;
        bus.waitrequest = 1'b1;
        step();
        chk("mem_stall_state", 32'(bus.state), 32'd2);
        reset = 1'b1;
        step();
        chk("memrst_state", 32'(bus.state), 32'd0);
        chk("memrst_pc", bus.pc, 32'hBFC0_0000);
        chk("memrst_count", bus.instr_count, 32'd0);
        reset = 1'b0;
        bus.waitrequest = 1'b0;

        // Jump to 0 at BFC00010; delay slot runs then halt
        for (int i = 0; i < 4; i++)
            run_instr(0, 0, 0, 0, 0,
                      32'hBFC0_0000 + 32'(4 * i), 32'(i));
        run_instr(0, 0, 0, 1, 32'h0, 32'hBFC0_0010, 32'd4);
        run_instr(0, 0, 0, 0, 0, 32'hBFC0_0014, 32'd5);
        chk("halt_state", 32'(bus.state), 32'd4);
        chk("halt_pc", bus.pc, 32'h0);
        chk("halt_count", bus.instr_count, 32'd6);
        chk("halt_strobes",
            {29'd0, bus.active, bus.ir_en, bus.commit}, 32'd0);
        s_pc  = bus.pc;
        s_cnt = bus.instr_count;
        s_ctl = {26'd0, 3'(bus.state),
                 bus.active, bus.ir_en, bus.commit};
        for (int i = 0; i < 10; i++) begin
            bus.waitrequest   = 1'($urandom_range(0, 1));
            bus.redirect      = 1'($urandom_range(0, 1));
            bus.is_mem_op     = 1'($urandom_range(0, 1));
            bus.redirect_addr = $urandom;
            step();
            chk("hold_pc", bus.pc, s_pc);
            chk("hold_count", bus.instr_count, s_cnt);
            chk("hold_ctl", {26'd0, 3'(bus.state), bus.active,
                             bus.ir_en, bus.commit}, s_ctl);
        end
        bus.redirect  = 1'b0;
        bus.is_mem_op = 1'b0;
        do_reset();
        chk("unhalt_state", 32'(bus.state), 32'd0);
        chk("unhalt_active", {31'd0, bus.active}, 32'd1);

        // Branch in the delay slot: last redirect wins
        for (int i = 0; i < 8; i++)
            run_instr(0, 0, 0, 0, 0,
                      32'hBFC0_0000 + 32'(4 * i), 32'(i));
        run_instr(0, 0, 0, 1, 32'hBFC0_0100,
                  32'hBFC0_0020, 32'd8);
        run_instr(1, 0, 0, 1, 32'hBFC0_0200,
                  32'hBFC0_0024, 32'd9);
        run_instr(0, 1, 1, 0, 0, 32'hBFC0_0100, 32'd10);
        run_instr(0, 0, 0, 0, 0, 32'hBFC0_0200, 32'd11);
        chk("final_pc", bus.pc, 32'hBFC0_0204);

        step();
        step();
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
